// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// Column drive is one-hot; a key code is {row_onehot, col_onehot}.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam logic [3:0] COL0 = 4'b0001;
  localparam logic [3:0] COL1 = 4'b0010;
  localparam logic [3:0] COL2 = 4'b0100;
  localparam logic [3:0] COL3 = 4'b1000;

  localparam logic [7:0] KEY_NONE = 8'h00;

  // Next column in the rotation; any illegal pattern recovers to COL0.
  function automatic logic [3:0] next_col(input logic [3:0] c);
    logic [3:0] n;
    case (c)
      COL0:    n = COL1;
      COL1:    n = COL2;
      COL2:    n = COL3;
      default: n = COL0;
    endcase
    return n;
  endfunction

  // True when exactly one row line is active.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: 4-bit two-flop synchronizer for the asynchronous row lines.
// Both stages clear to 0 on the asynchronous active-low reset.
module sync_2ff (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two back-to-back flops; only q is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 4'b0;
      q    <= 4'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time, debounces
// press and release, and reports the accepted key as {row_onehot, col_onehot}
// with a one-cycle key_valid pulse.
// Optional: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every
// REPEAT_CYCLES cycles while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 4000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [7:0] keypad_val,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  scan_state_t      state;
  logic [3:0]       rows_s;
  logic [3:0]       row_cap;
  logic [DIV_W-1:0] div_cnt;
  logic [DB_W-1:0]  db_cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  // Scan/debounce FSM with column rotation, counters and registered outputs.
  // Counters stop at their terminal value (the state changes there), so they
  // never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      cols       <= COL0;
      keypad_val <= KEY_NONE;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      row_cap    <= 4'b0;
      div_cnt    <= '0;
      db_cnt     <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (div_cnt >= DIV_LAST) begin
            div_cnt <= '0;
            if (is_onehot4(rows_s)) begin
              // Freeze on this column and qualify the single active row.
              row_cap <= rows_s;
              db_cnt  <= '0;
              state   <= DEBOUNCE;
            end else begin
              cols <= next_col(cols);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rows_s == row_cap) begin
            if (db_cnt >= DB_LAST) begin
              keypad_val <= {row_cap, cols};
              key_valid  <= 1'b1;
              key_held   <= 1'b1;
              db_cnt     <= '0;
              state      <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt    <= '0;
`endif
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            // Bounce or a second row appeared: drop the candidate silently.
            cols    <= next_col(cols);
            div_cnt <= '0;
            state   <= SCAN;
          end
        end

        HELD: begin
          // Only the captured row matters; extra rows in this column are ignored.
          if ((rows_s & row_cap) == 4'b0) begin
            db_cnt <= '0;
            state  <= RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_cnt >= REP_LAST) begin
            rep_cnt   <= '0;
            key_valid <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end

        RELEASE: begin
          if ((rows_s & row_cap) == 4'b0) begin
            if (db_cnt >= DB_LAST) begin
              key_held <= 1'b0;
              db_cnt   <= '0;
              cols     <= next_col(cols);
              div_cnt  <= '0;
              state    <= SCAN;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            // Release glitch: the key is still down, keep reporting it held.
            db_cnt <= '0;
            state  <= HELD;
          end
        end

        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule
